// File: rtl/sc_phase_pkg.sv
// sc_phase_pkg
// Shared definitions for the two-phase non-overlapping clock generator:
// the FSM state encoding and the default counter / config width.
// Optional feature macro used by the top level: SC_PHASE_GEN_EARLY_EN.
package sc_phase_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PHI1  = 3'd1,
        GAP12 = 3'd2,
        PHI2  = 3'd3,
        GAP21 = 3'd4
    } phase_state_t;

endpackage

// File: rtl/sc_phase_counter.sv
// sc_phase_counter
// Loadable down-counter that saturates at zero and flags when it reads zero.
// The FSM loads (length-1) on every state entry and leaves the state when
// the zero flag is seen, so a load value of 0 gives a one-cycle state.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (count clears to 0)
//   load      in   load load_val on this edge (takes priority over counting)
//   load_val  in   value to load, CNT_W bits
//   count     out  current counter value
//   zero      out  high while count == 0
module sc_phase_counter
    import sc_phase_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load wins; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sc_phase_generator.sv
// sc_phase_generator
// Non-overlapping two-phase clock generator for the switched-capacitor
// filter switches. Sequence per period: PHI1 (H cycles), GAP12 (G cycles),
// PHI2 (H cycles), GAP21 (G cycles); period = 2H + 2G cycles.
// H and G are shadow copies of cfg_high/cfg_gap (0 clamped to 1) captured
// only when a period starts, so mid-period config changes never disturb
// the period in flight. Dropping en lets the current period finish.
// Every output is a flop driven from the next-state decode, so the analog
// gate lines never see combinational glitches.
// Optional macro SC_PHASE_GEN_EARLY_EN adds phi1e/phi2e: early-opening
// copies of the phases that fall one cycle before phi1/phi2.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   en            in   run request, level-sensitive
//   cfg_high      in   phase high-time in clk cycles (0 treated as 1)
//   cfg_gap       in   dead-time in clk cycles (0 treated as 1)
//   phi1          out  sampling phase
//   phi2          out  transfer phase
//   period_start  out  one-cycle pulse on the first cycle of each phi1
//   busy          out  high whenever the FSM is not IDLE
//   phi1e, phi2e  out  early phases (only with SC_PHASE_GEN_EARLY_EN)
module sc_phase_generator
    import sc_phase_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_gap,
    output logic             phi1,
    output logic             phi2,
`ifdef SC_PHASE_GEN_EARLY_EN
    output logic             phi1e,
    output logic             phi2e,
`endif
    output logic             period_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    phase_state_t     state, state_next;
    logic [CNT_W-1:0] high_sh, gap_sh;
    logic [CNT_W-1:0] high_cl, gap_cl;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             latch_cfg;
    logic [CNT_W-1:0] count;
    logic             zero;

    // A zero length would make the FSM skip a state; treat it as one cycle.
    assign high_cl = (cfg_high == '0) ? ONE : cfg_high;
    assign gap_cl  = (cfg_gap  == '0) ? ONE : cfg_gap;

    sc_phase_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. Every transition reloads the counter with the new
    // state's length minus one. Entering PHI1 uses the freshly clamped
    // config because the shadows are captured on that same edge.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        latch_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = PHI1;
                    load       = 1'b1;
                    load_val   = high_cl - ONE;
                    latch_cfg  = 1'b1;
                end
            end
            PHI1: begin
                if (zero) begin
                    state_next = GAP12;
                    load       = 1'b1;
                    load_val   = gap_sh - ONE;
                end
            end
            GAP12: begin
                if (zero) begin
                    state_next = PHI2;
                    load       = 1'b1;
                    load_val   = high_sh - ONE;
                end
            end
            PHI2: begin
                if (zero) begin
                    state_next = GAP21;
                    load       = 1'b1;
                    load_val   = gap_sh - ONE;
                end
            end
            GAP21: begin
                if (zero) begin
                    load = 1'b1;
                    if (en) begin
                        state_next = PHI1;
                        load_val   = high_cl - ONE;
                        latch_cfg  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        load_val   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                load       = 1'b1;
                load_val   = '0;
            end
        endcase
    end

    // Shadow config, captured only at the start of a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_sh <= ONE;
            gap_sh  <= ONE;
        end else if (latch_cfg) begin
            high_sh <= high_cl;
            gap_sh  <= gap_cl;
        end
    end

    // Output flops follow the next state so they change on the same edge as
    // the state register, with no decode logic after the flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi1         <= 1'b0;
            phi2         <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            phi1         <= (state_next == PHI1);
            phi2         <= (state_next == PHI2);
            period_start <= latch_cfg;
            busy         <= (state_next != IDLE);
        end
    end

`ifdef SC_PHASE_GEN_EARLY_EN
    logic cnt_next_nz;

    // The counter value after this edge is nonzero either when a nonzero
    // length is being loaded, or when it is still above one and counting.
    assign cnt_next_nz = load ? (load_val != '0) : (count > ONE);

    // Early phases: high in PHI1/PHI2 except the last cycle of the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi1e <= 1'b0;
            phi2e <= 1'b0;
        end else begin
            phi1e <= (state_next == PHI1) && cnt_next_nz;
            phi2e <= (state_next == PHI2) && cnt_next_nz;
        end
    end
`endif

endmodule

// File: tb/tb_sc_phase_generator.sv
// tb_sc_phase_generator
// Directed bench for sc_phase_generator. Inputs change 1 ns after a rising
// edge and outputs are sampled there too. Expected per-cycle waveforms are
// written as bit masks where bit i is the value after the i-th edge of
// the step. Early-phase checks are compiled when SC_PHASE_GEN_EARLY_EN
// is defined.
`timescale 1ns/1ps
module tb_sc_phase_generator;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_gap;
    logic             phi1, phi2, period_start, busy;
`ifdef SC_PHASE_GEN_EARLY_EN
    logic             phi1e, phi2e;
`endif

    int compared   = 0;
    int mismatched = 0;

    sc_phase_generator #(
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_high     (cfg_high),
        .cfg_gap      (cfg_gap),
        .phi1         (phi1),
        .phi2         (phi2),
`ifdef SC_PHASE_GEN_EARLY_EN
        .phi1e        (phi1e),
        .phi2e        (phi2e),
`endif
        .period_start (period_start),
        .busy         (busy)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input int h, input int g);
        en       = e;
        cfg_high = CNT_W'(h);
        cfg_gap  = CNT_W'(g);
    endtask

    task automatic checkOutput(input string tag, input int idx,
                               input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    // Runs n edges, comparing {phi1,phi2,period_start,busy} each cycle
    // against the masks, plus the no-overlap invariant.
    task automatic runPattern(input string tag, input int n,
                              input logic [31:0] m1, input logic [31:0] m2,
                              input logic [31:0] mps, input logic [31:0] mb);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput(tag, i, {phi1, phi2, period_start, busy},
                        {m1[i], m2[i], mps[i], mb[i]});
            checkOutput({tag, "_overlap"}, i, {3'b000, phi1 & phi2}, 4'b0000);
        end
    endtask

`ifdef SC_PHASE_GEN_EARLY_EN
    task automatic runEarly(input string tag, input int n,
                            input logic [31:0] m1e, input logic [31:0] m2e);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput(tag, i, {2'b00, phi1e, phi2e}, {2'b00, m1e[i], m2e[i]});
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 3, 1);

        // Reset holds everything low.
        tick();
        tick();
        checkOutput("reset_state", 0, {phi1, phi2, period_start, busy}, 4'b0000);

        // Basic run H=3 G=1: period 8, restart on cycle 8.
        rst = 1'b0;
        tick();
        checkOutput("idle_after_reset", 0, {phi1, phi2, period_start, busy}, 4'b0000);
        applyStimulus(1'b1, 3, 1);
        runPattern("basic", 9, 32'h107, 32'h070, 32'h101, 32'h1FF);

        // Config goes to 0/0 mid-PHI1: this period stays H=3 G=1,
        // the following periods run clamped at H=1 G=1 (period 4).
        applyStimulus(1'b1, 0, 0);
        runPattern("hold_cfg", 7, 32'h03, 32'h38, 32'h00, 32'h7F);
        runPattern("clamp", 8, 32'h11, 32'h44, 32'h11, 32'hFF);

        // Graceful stop: H=4 G=2, en dropped in the 2nd cycle of PHI1.
        applyStimulus(1'b1, 4, 2);
        runPattern("stop_start", 2, 32'h3, 32'h0, 32'h1, 32'h3);
        applyStimulus(1'b0, 4, 2);
        runPattern("stop_finish", 12, 32'h003, 32'h0F0, 32'h000, 32'h3FF);

        // Mid-period change H 3->5 during PHI2.
        applyStimulus(1'b1, 3, 1);
        runPattern("chg_before", 5, 32'h07, 32'h10, 32'h01, 32'h1F);
        applyStimulus(1'b1, 5, 1);
        runPattern("chg_after", 9, 32'h0F8, 32'h003, 32'h008, 32'h1FF);

        // Async reset mid-PHI2.
        runPattern("pre_reset", 1, 32'h0, 32'h1, 32'h0, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 0, {phi1, phi2, period_start, busy}, 4'b0000);
        tick();
        checkOutput("reset_held", 0, {phi1, phi2, period_start, busy}, 4'b0000);
        rst = 1'b0;
        runPattern("restart", 1, 32'h1, 32'h0, 32'h1, 32'h1);

`ifdef SC_PHASE_GEN_EARLY_EN
        // Early phases: H=3 high two cycles; H=1 never high.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 3, 1);
        runEarly("early_h3", 8, 32'h03, 32'h30);
        applyStimulus(1'b1, 1, 1);
        runEarly("early_h1", 8, 32'h00, 32'h00);
`endif

        // Stop and wait, bounded, for the FSM to go idle.
        applyStimulus(1'b0, 1, 1);
        for (int i = 0; i < 64 && busy; i++) begin
            tick();
        end
        checkOutput("final_idle", 0, {phi1, phi2, period_start, busy}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
